processador_multiciclo_param: RTL and testbench

PROCESSADOR_MULTICICLO_PARAM -- requirements
Module: processador_multiciclo_param

---
 rtl/processador_multiciclo_param.sv | 115 +++++++++++
 tb/tb_processador_multiciclo_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/processador_multiciclo_param.sv
// Multicycle processor: eight DATA_W registers, accumulator A and result G share one bus.
// Instructions take 1 (mv/mvi/NOP) or 3 (ALU) steps after the T0 fetch step.
module processador_multiciclo_param #(
    parameter int DATA_W     = 16,
    parameter int ENABLE_EXT = 1
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires
);

    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

    step_t             step, step_nxt;
    logic [8:0]        ir;
    logic [DATA_W-1:0] regs [8];
    logic [DATA_W-1:0] a_reg, g_reg, bus;
    logic              done_c, ir_ld, a_ld, g_ld, rx_wr, is_alu;
    logic [2:0]        opcode, rx, ry;

    assign opcode = ir[8:6];
    assign rx     = ir[5:3];
    assign ry     = ir[2:0];
    assign is_alu = (opcode == 3'b010) || (opcode == 3'b011) || (opcode[2] && (ENABLE_EXT != 0));

    // add/sub wrap modulo 2^DATA_W; slt compares as signed two's complement
    function automatic logic [DATA_W-1:0] alu_result(input logic [2:0] op,
                                                     input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        case (op)
            3'b010:  r = a + b;
            3'b011:  r = a - b;
            3'b100:  r = a & b;
            3'b101:  r = a | b;
            3'b110:  r = a ^ b;
            3'b111:  r = {{(DATA_W-1){1'b0}}, (a < b)};
            default: r = b;
        endcase
        return r;
    endfunction

    always_comb begin
        step_nxt = step;
        bus      = '0;
        done_c   = 1'b0;
        ir_ld    = 1'b0;
        a_ld     = 1'b0;
        g_ld     = 1'b0;
        rx_wr    = 1'b0;
        case (step)
            T0: begin
                if (Run) begin
                    ir_ld    = 1'b1;
                    step_nxt = T1;
                end
            end
            T1: begin
                if (opcode == 3'b000) begin
                    bus      = regs[ry];
                    rx_wr    = 1'b1;
                    done_c   = 1'b1;
                    step_nxt = T0;
                end else if (opcode == 3'b001) begin
                    bus      = DIN;
                    rx_wr    = 1'b1;
                    done_c   = 1'b1;
                    step_nxt = T0;
                end else if (is_alu) begin
                    bus      = regs[rx];
                    a_ld     = 1'b1;
                    step_nxt = T2;
                end else begin
                    // disabled extension opcode: single-step no-op
                    done_c   = 1'b1;
                    step_nxt = T0;
                end
            end
            T2: begin
                bus      = regs[ry];
                g_ld     = 1'b1;
                step_nxt = T3;
            end
            default: begin
                bus      = g_reg;
                rx_wr    = 1'b1;
                done_c   = 1'b1;
                step_nxt = T0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            step  <= T0;
            ir    <= '0;
            a_reg <= '0;
            g_reg <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            step <= step_nxt;
            if (ir_ld) ir    <= DIN[8:0];
            if (a_ld)  a_reg <= bus;
            if (g_ld)  g_reg <= alu_result(opcode, a_reg, bus);
            if (rx_wr) regs[rx] <= bus;
        end
    end

    assign Done     = done_c;
    assign BusWires = bus;

endmodule

// File: tb/tb_processador_multiciclo_param.sv
// Randomized scoreboard bench: a 16-bit extended core and a 32-bit non-extended core,
// exercised one after the other against an instruction-level reference model.
module tb_processador_multiciclo_param;

    logic        Clock = 1'b0;
    logic        Resetn, Run;
    logic [31:0] DIN;
    logic        Done16, Done32;
    logic [15:0] Bus16;
    logic [31:0] Bus32;

    processador_multiciclo_param #(.DATA_W(16), .ENABLE_EXT(1)) u_dut16 (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN[15:0]),
        .Done(Done16), .BusWires(Bus16)
    );

    processador_multiciclo_param #(.DATA_W(32), .ENABLE_EXT(0)) u_dut32 (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
        .Done(Done32), .BusWires(Bus32)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit          sel;
        logic [31:0] bus;
        logic        done;
        int          id;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          icount = 0;
    bit          sel;
    int          W;
    bit          EXT;
    logic [31:0] m_regs [8];

    // Monitor: one expectation per clock cycle, sampled mid-cycle
    always @(negedge Clock) begin
        exp_t        e;
        logic [31:0] act_bus;
        logic        act_done;
        if (sb.size() > 0) begin
            e        = sb.pop_front();
            act_bus  = e.sel ? Bus32 : {16'h0, Bus16};
            act_done = e.sel ? Done32 : Done16;
            checks++;
            if (act_bus !== e.bus) begin
                failures++;
                $display("FAIL bus instr=%0d width=%0d actual=%h required=%h", e.id, e.sel ? 32 : 16, act_bus, e.bus);
            end
            checks++;
            if (act_done !== e.done) begin
                failures++;
                $display("FAIL done instr=%0d width=%0d actual=%b required=%b", e.id, e.sel ? 32 : 16, act_done, e.done);
            end
        end
    end

    function automatic logic [31:0] mask_w(input logic [31:0] v);
        if (W == 32) return v;
        return v & ((32'h1 << W) - 32'h1);
    endfunction

    function automatic longint sval(input logic [31:0] v);
        longint u;
        u = longint'(v);
        if (v[W-1]) return u - (longint'(1) << W);
        return u;
    endfunction

    function automatic logic [31:0] model_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2: return mask_w(a + b);
            3: return mask_w(a - b);
            4: return a & b;
            5: return a | b;
            6: return a ^ b;
            default: return (sval(a) < sval(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic cyc(input logic [31:0] din, input logic run, input logic rstn,
                       input logic [31:0] eb, input logic ed, input bit push);
        exp_t e;
        DIN    = din;
        Run    = run;
        Resetn = rstn;
        if (push) begin
            e.sel  = sel;
            e.bus  = eb;
            e.done = ed;
            e.id   = icount;
            sb.push_back(e);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        cyc($urandom(), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc($urandom(), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
        // first cycle out of reset: idle T0 with Run low
        cyc($urandom(), 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] instr_word(input int op, input int rx, input int ry);
        logic [31:0] w;
        w      = $urandom();
        w[8:6] = op[2:0];
        w[5:3] = rx[2:0];
        w[2:0] = ry[2:0];
        return w;
    endfunction

    task automatic do_instr(input int op, input int rx, input int ry, input logic [31:0] imm, input int idle);
        logic [31:0] a, b, g;
        icount++;
        for (int i = 0; i < idle; i++) cyc($urandom(), 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        cyc(instr_word(op, rx, ry), 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
        if (op == 0) begin
            cyc($urandom(), 1'($urandom_range(0, 1)), 1'b1, m_regs[ry], 1'b1, 1'b1);
            m_regs[rx] = m_regs[ry];
        end else if (op == 1) begin
            cyc(imm, 1'($urandom_range(0, 1)), 1'b1, mask_w(imm), 1'b1, 1'b1);
            m_regs[rx] = mask_w(imm);
        end else if (op < 4 || EXT) begin
            a = m_regs[rx];
            cyc($urandom(), 1'($urandom_range(0, 1)), 1'b1, a, 1'b0, 1'b1);
            b = m_regs[ry];
            g = model_alu(op, a, b);
            cyc($urandom(), 1'($urandom_range(0, 1)), 1'b1, b, 1'b0, 1'b1);
            cyc($urandom(), 1'($urandom_range(0, 1)), 1'b1, g, 1'b1, 1'b1);
            m_regs[rx] = g;
        end else begin
            cyc($urandom(), 1'($urandom_range(0, 1)), 1'b1, 32'h0, 1'b1, 1'b1);
        end
    endtask

    task automatic random_instrs(input int n);
        for (int i = 0; i < n; i++)
            do_instr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom(), $urandom_range(0, 2));
    endtask

    task automatic dump_regs();
        for (int k = 0; k < 8; k++) do_instr(0, k, k, 32'h0, 0);
    endtask

    initial begin
        Resetn = 1'b0;
        Run    = 1'b0;
        DIN    = 32'h0;

        sel = 1'b0; W = 16; EXT = 1'b1;
        do_reset();
        do_instr(1, 0, 0, 32'hABCD_0005, 0);
        do_instr(0, 1, 0, 32'h0, 0);
        do_instr(2, 0, 1, 32'h0, 0);
        do_instr(1, 2, 0, 32'h0, 1);
        do_instr(3, 2, 0, 32'h0, 0);
        do_instr(7, 2, 0, 32'h0, 0);
        do_instr(6, 0, 0, 32'h0, 0);
        do_instr(2, 3, 3, 32'h0, 0);
        random_instrs(60);
        dump_regs();

        // reset asserted during T2 of add R0,R1 aborts it
        icount++;
        cyc(instr_word(2, 0, 1), 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
        cyc($urandom(), 1'b1, 1'b1, m_regs[0], 1'b0, 1'b1);
        cyc($urandom(), 1'b1, 1'b0, m_regs[1], 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
        cyc($urandom(), 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        dump_regs();
        random_instrs(20);

        sel = 1'b1; W = 32; EXT = 1'b0;
        do_reset();
        do_instr(1, 0, 0, 32'h0000_0005, 0);
        do_instr(0, 1, 0, 32'h0, 0);
        do_instr(2, 0, 1, 32'h0, 0);
        do_instr(1, 2, 0, 32'h0, 0);
        do_instr(3, 2, 0, 32'h0, 0);
        do_instr(4, 0, 1, 32'h0, 0);
        do_instr(7, 2, 0, 32'h0, 0);
        dump_regs();
        random_instrs(40);
        dump_regs();

        cyc($urandom(), 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        @(posedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
